cubehash_host: RTL and testbench

CUBEHASH_HOST -- requirements
Module: cubehash_host

---
 rtl/cubehash_pkg.sv | 22 ++
 rtl/cubehash_word_mux.sv | 17 +
 rtl/cubehash_host.sv | 146 ++++++++++++++
 tb/tb_cubehash_host.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cubehash_pkg.sv
// Shared types and sizes for the CubeHash host: block/word geometry and FSM states.
package cubehash_pkg;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BLK_W  = 256;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    FETCH = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // MSB position of word k inside a block, word 0 being the most significant.
  function automatic int unsigned word_msb(input int unsigned k);
    return BLK_W - 1 - WORD_W * k;
  endfunction
endpackage

// File: rtl/cubehash_word_mux.sv
// Selects one 16-bit word out of a 256-bit block, word 0 being the most significant.
module cubehash_word_mux
  import cubehash_pkg::*;
(
  input  logic [BLK_W-1:0]  blk,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx == IDX_W'(i)) word = blk[word_msb(i) -: WORD_W];
    end
  end

endmodule

// File: rtl/cubehash_host.sv
// Host sequencer for a word-serial CubeHash core: streams 256-bit message blocks
// in as 16-bit words, waits for the core ack and gathers the digest back.
module cubehash_host #(
  parameter int unsigned WORDS       = 16,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               msg_valid,
  output logic                               msg_ready,
  input  logic [cubehash_pkg::BLK_W-1:0]     msg_data,
  input  logic                               msg_first,
  input  logic                               msg_last,
  output logic                               dig_valid,
  input  logic                               dig_ready,
  output logic [cubehash_pkg::BLK_W-1:0]     dig_data,
  output logic                               err,
  output logic                               hc_init,
  output logic                               hc_load,
  output logic [cubehash_pkg::WORD_W-1:0]    hc_idata,
  output logic                               hc_fetch,
  input  logic [cubehash_pkg::WORD_W-1:0]    hc_odata,
  input  logic                               hc_ack
);
  import cubehash_pkg::*;

  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t              state;
  logic [BLK_W-1:0]    msg_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt;
  logic [TO_W-1:0]     tcnt;
  logic [WORD_W-1:0]   mux_word;
  logic [IDX_W-1:0]    cap_idx;

  // Ready is a pure decode of the state register, forced low while in reset.
  assign msg_ready = (state == IDLE) && !rst;

  // In FETCH, the word arriving now belongs to the previous fetch cycle.
  assign cap_idx = IDX_W'(cnt - 1'b1);

  cubehash_word_mux u_word_mux (
    .blk  (msg_q),
    .idx  (cnt[IDX_W-1:0]),
    .word (mux_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      msg_q     <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      dig_valid <= 1'b0;
      dig_data  <= '0;
      err       <= 1'b0;
      hc_init   <= 1'b0;
      hc_load   <= 1'b0;
      hc_fetch  <= 1'b0;
      hc_idata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (msg_valid) begin
            msg_q  <= msg_data;
            last_q <= msg_last;
            if (msg_first) begin
              state   <= INIT;
              hc_init <= 1'b1;
              cnt     <= '0;
            end else begin
              // Chained block: core keeps its state, first word comes straight from the input.
              state    <= LOAD;
              hc_load  <= 1'b1;
              hc_idata <= msg_data[BLK_W-1 -: WORD_W];
              cnt      <= CNT_W'(1);
            end
          end
        end
        INIT: begin
          state    <= LOAD;
          hc_init  <= 1'b0;
          hc_load  <= 1'b1;
          hc_idata <= mux_word;
          cnt      <= CNT_W'(1);
        end
        LOAD: begin
          if (cnt == CNT_W'(WORDS)) begin
            state   <= WAIT;
            hc_load <= 1'b0;
            tcnt    <= '0;
          end else begin
            hc_idata <= mux_word;
            cnt      <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (hc_ack) begin
            if (last_q) begin
              state    <= FETCH;
              hc_fetch <= 1'b1;
              cnt      <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (tcnt == TO_W'(ACK_TIMEOUT - 1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FETCH: begin
          if (cnt != '0) begin
            for (int i = 0; i < int'(WORDS); i++) begin
              if (cap_idx == IDX_W'(i)) dig_data[word_msb(i) -: WORD_W] <= hc_odata;
            end
          end
          if (cnt == CNT_W'(WORDS - 1)) hc_fetch <= 1'b0;
          if (cnt == CNT_W'(WORDS)) begin
            state     <= DONE;
            dig_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (dig_ready) begin
            state     <= IDLE;
            dig_valid <= 1'b0;
          end
        end
        ERR: begin
          hc_init  <= 1'b0;
          hc_load  <= 1'b0;
          hc_fetch <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cubehash_host.sv
// Self-checking bench for cubehash_host: vector table, hand-written corner sequences
// and randomized blocks checked against a behavioural model of the host protocol.
module tb_cubehash_host;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [255:0] msg_data = '0;
  logic         msg_first = 1'b0;
  logic         msg_last = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b0;
  logic [255:0] dig_data;
  logic         err;
  logic         hc_init;
  logic         hc_load;
  logic [15:0]  hc_idata;
  logic         hc_fetch;
  logic [15:0]  hc_odata = '0;
  logic         hc_ack = 1'b0;

  cubehash_host #(.WORDS(16), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_first(msg_first), .msg_last(msg_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .err(err),
    .hc_init(hc_init), .hc_load(hc_load), .hc_idata(hc_idata),
    .hc_fetch(hc_fetch), .hc_odata(hc_odata), .hc_ack(hc_ack)
  );

  always #5 clk = ~clk;

  // Protocol monitors: strobe counts, captured load words, exclusivity violations.
  int          init_cnt = 0;
  int          load_cnt = 0;
  int          fetch_cnt = 0;
  int          excl_bad = 0;
  logic [15:0] load_mem [0:255];
  always @(posedge clk) begin
    if (hc_init) init_cnt <= init_cnt + 1;
    if (hc_load) begin
      load_mem[load_cnt[7:0]] <= hc_idata;
      load_cnt <= load_cnt + 1;
    end
    if (hc_fetch) fetch_cnt <= fetch_cnt + 1;
    if (int'(hc_init) + int'(hc_load) + int'(hc_fetch) > 1) excl_bad <= excl_bad + 1;
  end

  // Core stand-in: answers fetch k with base+k on the following cycle.
  logic [15:0] odata_base = '0;
  logic [15:0] fidx = '0;
  always @(posedge clk) begin
    if (hc_load) fidx <= '0;
    else if (hc_fetch) begin
      hc_odata <= odata_base + fidx;
      fidx     <= fidx + 1'b1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  function automatic logic [15:0] ref_word(input logic [255:0] m, input int k);
    logic [255:0] t;
    t = m >> (16 * (15 - k));
    return t[15:0];
  endfunction

  function automatic logic [255:0] ref_digest(input logic [15:0] base);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) d = {d[239:0], 16'(base + 16'(k))};
    return d;
  endfunction

  function automatic int ref_latency(input logic f, input int w);
    return (f ? 1 : 0) + 16 + w + 17;
  endfunction

  task automatic accept(input string tag, input logic [255:0] m, input logic f, input logic l);
    int n;
    n = 0;
    while (!msg_ready && n < 50) begin tick(); n++; end
    chk({tag, " ready"}, 256'(msg_ready), 256'(1));
    msg_valid = 1'b1; msg_data = m; msg_first = f; msg_last = l;
    tick();
    msg_valid = 1'b0;
    chk({tag, " busy"}, 256'(msg_ready), 256'(0));
  endtask

  // One block through load, wait (ack on WAIT cycle w), optional fetch/done.
  task automatic run_block(input string tag, input logic [255:0] m, input logic f, input logic l,
                           input int w, input int hold, input logic spur, input logic [15:0] base,
                           input int exp_lat);
    int i0, l0, f0, n, lead;
    logic [255:0] got, snap;
    logic stable;
    odata_base = base;
    i0 = init_cnt; l0 = load_cnt; f0 = fetch_cnt;
    accept(tag, m, f, l);
    lead = f ? 17 : 16;
    for (int k = 0; k < lead - 1 + w; k++) begin
      hc_ack = (spur && k == 4);
      tick();
    end
    hc_ack = 1'b1;
    tick();
    hc_ack = 1'b0;
    chk({tag, " loads"}, 256'(load_cnt - l0), 256'(16));
    got = '0;
    for (int k = 0; k < 16; k++) got = {got[239:0], load_mem[8'(l0 + k)]};
    chk({tag, " words"}, got, m);
    chk({tag, " inits"}, 256'(init_cnt - i0), 256'(f ? 1 : 0));
    if (!l) begin
      chk({tag, " back idle"}, 256'(msg_ready), 256'(1));
      chk({tag, " no fetch"}, 256'(fetch_cnt - f0), 256'(0));
      return;
    end
    n = 0;
    while (!dig_valid && n < 60) begin tick(); n++; end
    chk({tag, " latency"}, 256'(lead + w + n), 256'(exp_lat));
    chk({tag, " fetches"}, 256'(fetch_cnt - f0), 256'(16));
    chk({tag, " digest"}, dig_data, ref_digest(base));
    snap = dig_data;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!dig_valid || dig_data !== snap || msg_ready) stable = 1'b0;
    end
    chk({tag, " hold"}, 256'(stable), 256'(1));
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    chk({tag, " release"}, 256'({dig_valid, msg_ready}), 256'(2'b01));
  endtask

  typedef struct {
    logic [255:0] msg;
    logic         first;
    logic         last;
    int           w;
    int           hold;
    logic         spur;
    logic [15:0]  base;
    int           exp_lat;
  } vec_t;

  vec_t tab [5];

  initial begin
    logic [255:0] m;
    logic f, l;
    int w, n;
    logic ok;

    tab[0] = '{{4{64'h0123456789ABCDEF}}, 1'b1, 1'b1, 5, 0, 1'b0, 16'h1000, 39};
    tab[1] = '{rand256(), 1'b1, 1'b1, 1, 2, 1'b1, 16'(($urandom())), 35};
    tab[2] = '{rand256(), 1'b1, 1'b1, 8, 20, 1'b0, 16'hFFF8, 42};
    tab[3] = '{rand256(), 1'b1, 1'b0, 3, 0, 1'b0, 16'h0000, 0};
    tab[4] = '{rand256(), 1'b0, 1'b1, 2, 1, 1'b1, 16'h2200, 35};

    // Reset state
    repeat (3) tick();
    chk("rst strobes", 256'({msg_ready, dig_valid, err, hc_init, hc_load, hc_fetch}), 256'(0));
    chk("rst idata", 256'(hc_idata), 256'(0));
    chk("rst digest", dig_data, 256'(0));
    rst = 1'b0;
    tick();
    chk("idle ready", 256'(msg_ready), 256'(1));

    // Vector table: includes the reference block and a two-block chain (3 then 4)
    for (int i = 0; i < 5; i++)
      run_block($sformatf("vec%0d", i), tab[i].msg, tab[i].first, tab[i].last, tab[i].w,
                tab[i].hold, tab[i].spur, tab[i].base, tab[i].exp_lat);

    // Reset during load word 7, then a fresh block
    m = rand256();
    accept("midload", m, 1'b1, 1'b1);
    repeat (8) tick();
    chk("midload word7", 256'({hc_load, hc_idata}), 256'({1'b1, ref_word(m, 7)}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midload abort", 256'({hc_load, msg_ready, dig_valid}), 256'(3'b010));
    run_block("after midload", rand256(), 1'b1, 1'b1, 4, 0, 1'b0, 16'h3300, ref_latency(1'b1, 4));

    // Reset during fetch: no partial digest may appear
    accept("midfetch", rand256(), 1'b1, 1'b1);
    repeat (21) tick();
    hc_ack = 1'b1;
    tick();
    hc_ack = 1'b0;
    repeat (6) tick();
    chk("midfetch fetching", 256'(hc_fetch), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dig_valid || hc_fetch) ok = 1'b0;
    end
    chk("midfetch no digest", 256'(ok), 256'(1));
    run_block("after midfetch", rand256(), 1'b1, 1'b1, 2, 0, 1'b0, 16'h4400, ref_latency(1'b1, 2));

    // Randomized blocks
    for (int i = 0; i < 12; i++) begin
      f = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      w = int'($urandom_range(1, TO));
      run_block($sformatf("rnd%0d", i), rand256(), f, l, w, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 16'($urandom()), ref_latency(f, w));
    end

    // Ack timeout: err exactly TO cycles into WAIT, sticky until reset
    accept("timeout", rand256(), 1'b1, 1'b1);
    repeat (16 + TO) tick();
    chk("timeout early", 256'(err), 256'(0));
    tick();
    chk("timeout err", 256'(err), 256'(1));
    chk("timeout quiet", 256'({hc_init, hc_load, hc_fetch, msg_ready}), 256'(0));
    hc_ack = 1'b1;
    msg_valid = 1'b1;
    repeat (5) tick();
    hc_ack = 1'b0;
    msg_valid = 1'b0;
    chk("timeout sticky", 256'({err, msg_ready, hc_fetch}), 256'(3'b100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("timeout cleared", 256'({err, msg_ready}), 256'(2'b01));

    n = 0;
    repeat (2) begin tick(); n++; end
    chk("exclusive strobes", 256'(excl_bad), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
